gtx_tx_phase_sync: RTL and testbench

- Sequences the GTX transmitter PMA phase alignment after the trigger-clock start controller releases the transceiver reset.
- Feeds that controller's SYNC_DONE input and consumes its GTX_RST output, so it sits directly upstream of the controller in the trigger-link bring-up chain.
- Drives the GTX TXENPMAPHASEALIGN and TXPMASETPHASE pins with timed, counter-controlled phases.
- Reports completion once the TX phase is locked.

---
 rtl/trg_link_pkg.sv | 43 ++++
 rtl/gtx_tx_phase_sync.sv | 147 ++++++++++++++
 tb/tb_gtx_tx_phase_sync.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/trg_link_pkg.sv
// Shared definitions for the trigger-link bring-up chain.
// Latency: n/a (types, constants and constant functions only).
// Backpressure: n/a.
//
// Contents:
//    tx_sync_state_t    : GTX TX phase-sync sequencer state encoding
//    DEF_*              : default phase timings and counter width
//    SYNC_CNT_MAX       : saturation value of the completed-sync counter
//    max3 / cnt_width   : constant helpers used to size and check CNT_W
package trg_link_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_SETTLE    = 3'd1,
      ST_ALIGN     = 3'd2,
      ST_SETPHASE  = 3'd3,
      ST_DONE      = 3'd4
   } tx_sync_state_t;

   localparam int unsigned DEF_SETTLE_CYCLES = 32;
   localparam int unsigned DEF_ALIGN_CYCLES  = 512;
   localparam int unsigned DEF_PHASE_CYCLES  = 8192;
   localparam int unsigned DEF_CNT_W         = 14;

   localparam logic [7:0] SYNC_CNT_MAX = 8'd255;

   function automatic int unsigned max3(input int unsigned a,
                                        input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return m;
   endfunction

   // Bits needed to hold the terminal count n-1 of an n-cycle phase.
   function automatic int unsigned cnt_width(input int unsigned n);
      if (n <= 2) return 1;
      return $clog2(n);
   endfunction

endpackage

// File: rtl/gtx_tx_phase_sync.sv
// GTX TX PMA phase-alignment sequencer: Settle -> Align -> SetPhase -> Done.
// Latency: qualifying sample at edge 1 -> SYNC_DONE at edge SETTLE+ALIGN+PHASE+1.
// Backpressure: none; GTX_RST high or TXRESETDONE low aborts to Idle on the next edge.
//
// Ports:
//    CLK                in   TXUSRCLK2-domain clock
//    RST                in   synchronous, active-high reset
//    GTX_RST            in   transceiver reset from the trigger-clock start controller
//    TXRESETDONE        in   GTX reset-done, already synchronised to CLK
//    TXENPMAPHASEALIGN  out  GTX enable PMA phase alignment
//    TXPMASETPHASE      out  GTX set phase
//    SYNC_DONE          out  TX phase aligned (level)
//    SYNC_CNT           out  completed-sync count, saturating at 255
//                            (only when TX_SYNC_CNT_EN is defined)
//
// Build option: define TX_SYNC_CNT_EN to add the SYNC_CNT port and counter.
module gtx_tx_phase_sync
   import trg_link_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES,
   parameter int unsigned ALIGN_CYCLES  = DEF_ALIGN_CYCLES,
   parameter int unsigned PHASE_CYCLES  = DEF_PHASE_CYCLES,
   parameter int unsigned CNT_W         = DEF_CNT_W
)(
   input  logic       CLK,
   input  logic       RST,
   input  logic       GTX_RST,
   input  logic       TXRESETDONE,
   output logic       TXENPMAPHASEALIGN,
   output logic       TXPMASETPHASE,
   output logic       SYNC_DONE
`ifdef TX_SYNC_CNT_EN
   ,
   output logic [7:0] SYNC_CNT
`endif
);

   // ------------------------------------------------------------------
   // Static configuration checks
   // ------------------------------------------------------------------
   if (CNT_W < cnt_width(max3(SETTLE_CYCLES, ALIGN_CYCLES, PHASE_CYCLES))) begin : g_cnt_w_err
      $error("gtx_tx_phase_sync: CNT_W=%0d cannot hold the largest terminal count", CNT_W);
   end

   if (SETTLE_CYCLES < 2 || ALIGN_CYCLES < 2 || PHASE_CYCLES < 2) begin : g_min_err
      $error("gtx_tx_phase_sync: every phase must last at least 2 cycles");
   end

   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] ALIGN_LAST  = CNT_W'(ALIGN_CYCLES - 1);
   localparam logic [CNT_W-1:0] PHASE_LAST  = CNT_W'(PHASE_CYCLES - 1);

   tx_sync_state_t   state_q;
   tx_sync_state_t   state_d;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             cnt_inc;
   logic             abort;
   logic             en_d;
   logic             set_d;
   logic             done_d;

   // Either the controller holding the transceiver in reset or the GTX
   // losing reset-done invalidates any alignment in progress.
   assign abort = GTX_RST | ~TXRESETDONE;

   // ------------------------------------------------------------------
   // Next-state, counter and output decode
   // ------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      cnt_inc = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            state_d = ST_SETTLE;
         end
         ST_SETTLE: begin
            if (cnt_q == SETTLE_LAST) state_d = ST_ALIGN;
            else                      cnt_inc = 1'b1;
         end
         ST_ALIGN: begin
            if (cnt_q == ALIGN_LAST) state_d = ST_SETPHASE;
            else                     cnt_inc = 1'b1;
         end
         ST_SETPHASE: begin
            if (cnt_q == PHASE_LAST) state_d = ST_DONE;
            else                     cnt_inc = 1'b1;
         end
         ST_DONE: begin
            state_d = ST_DONE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Abort outranks every transition, including holding in Done.
      if (abort) state_d = ST_IDLE;

      // Counter only survives an edge when staying in a timed state; any
      // state change or abort leaves it at zero for the next entry.
      cnt_d = (cnt_inc && !abort) ? cnt_q + CNT_W'(1) : '0;

      // Outputs follow the state being entered so they move with it.
      en_d   = (state_d == ST_ALIGN) || (state_d == ST_SETPHASE) || (state_d == ST_DONE);
      set_d  = (state_d == ST_SETPHASE);
      done_d = (state_d == ST_DONE);
   end

   // ------------------------------------------------------------------
   // State, counter and output registers
   // ------------------------------------------------------------------
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q           <= ST_IDLE;
         cnt_q             <= '0;
         TXENPMAPHASEALIGN <= 1'b0;
         TXPMASETPHASE     <= 1'b0;
         SYNC_DONE         <= 1'b0;
      end else begin
         state_q           <= state_d;
         cnt_q             <= cnt_d;
         TXENPMAPHASEALIGN <= en_d;
         TXPMASETPHASE     <= set_d;
         SYNC_DONE         <= done_d;
      end
   end

`ifdef TX_SYNC_CNT_EN
   // ------------------------------------------------------------------
   // Completed-sync counter: survives GTX_RST, cleared only by RST
   // ------------------------------------------------------------------
   logic done_entry;

   assign done_entry = (state_d == ST_DONE) && (state_q != ST_DONE);

   always_ff @(posedge CLK) begin
      if (RST) begin
         SYNC_CNT <= '0;
      end else if (done_entry && (SYNC_CNT != SYNC_CNT_MAX)) begin
         SYNC_CNT <= SYNC_CNT + 8'd1;
      end
   end
`endif

endmodule

// File: tb/tb_gtx_tx_phase_sync.sv
// Directed bench for gtx_tx_phase_sync with SETTLE=4, ALIGN=8, PHASE=16.
// Edge numbering: inputs changed just after edge 0 are first sampled at edge 1.
// Expected timeline: EN from edge 5, SET on edges 13..28, SYNC_DONE from edge 29.
module tb_gtx_tx_phase_sync;

   localparam int unsigned SETTLE = 4;
   localparam int unsigned ALIGN  = 8;
   localparam int unsigned PHASE  = 16;

   // Hand-computed edges for the parameters above.
   localparam int EN_EDGE   = 5;
   localparam int SET_EDGE  = 13;
   localparam int DONE_EDGE = 29;

   logic       CLK;
   logic       RST;
   logic       GTX_RST;
   logic       TXRESETDONE;
   logic       TXENPMAPHASEALIGN;
   logic       TXPMASETPHASE;
   logic       SYNC_DONE;
`ifdef TX_SYNC_CNT_EN
   logic [7:0] SYNC_CNT;
`endif

   int n_checks = 0;
   int n_errors = 0;
   int exp_cnt  = 0;

   gtx_tx_phase_sync #(
      .SETTLE_CYCLES (SETTLE),
      .ALIGN_CYCLES  (ALIGN),
      .PHASE_CYCLES  (PHASE),
      .CNT_W         (5)
   ) dut (
      .CLK               (CLK),
      .RST               (RST),
      .GTX_RST           (GTX_RST),
      .TXRESETDONE       (TXRESETDONE),
      .TXENPMAPHASEALIGN (TXENPMAPHASEALIGN),
      .TXPMASETPHASE     (TXPMASETPHASE),
      .SYNC_DONE         (SYNC_DONE)
`ifdef TX_SYNC_CNT_EN
      ,
      .SYNC_CNT          (SYNC_CNT)
`endif
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // {EN, SET, DONE} expected k edges after a qualifying start at edge 0.
   function automatic logic [2:0] exp_out(input int k);
      if (k >= DONE_EDGE) return 3'b101;
      if (k >= SET_EDGE)  return 3'b110;
      if (k >= EN_EDGE)   return 3'b100;
      return 3'b000;
   endfunction

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic test_reset();
      logic [2:0] got;
      RST = 1'b1; GTX_RST = 1'b1; TXRESETDONE = 1'b0;
      step();
      step();
      got = {TXENPMAPHASEALIGN, TXPMASETPHASE, SYNC_DONE};
      n_checks++;
      if (got !== 3'b000) begin
         n_errors++;
         $display("FAIL reset_outputs: got %b want 000", got);
      end
`ifdef TX_SYNC_CNT_EN
      n_checks++;
      if (SYNC_CNT !== 8'd0) begin
         n_errors++;
         $display("FAIL reset_sync_cnt: got %0d want 0", SYNC_CNT);
      end
`endif
      RST = 1'b0;
      step();
   endtask

   task automatic test_bringup();
      logic [2:0] got;
      GTX_RST = 1'b0; TXRESETDONE = 1'b1;            // edge 0
      for (int k = 1; k <= 32; k++) begin
         step();
         got = {TXENPMAPHASEALIGN, TXPMASETPHASE, SYNC_DONE};
         n_checks++;
         if (got !== exp_out(k)) begin
            n_errors++;
            $display("FAIL bringup edge %0d: got %b want %b", k, got, exp_out(k));
         end
      end
      exp_cnt = 1;
`ifdef TX_SYNC_CNT_EN
      n_checks++;
      if (SYNC_CNT !== 8'(exp_cnt)) begin
         n_errors++;
         $display("FAIL bringup_sync_cnt: got %0d want %0d", SYNC_CNT, exp_cnt);
      end
`endif
   endtask

   task automatic test_abort_setphase();
      logic [2:0] got;
      logic [2:0] exp;
      GTX_RST = 1'b1;
      step();
      step();
      GTX_RST = 1'b0;                                 // edge 0
      for (int k = 1; k <= 60; k++) begin
         step();
         if (k <= 20)      exp = exp_out(k);
         else if (k <= 30) exp = 3'b000;
         else              exp = exp_out(k - 30);
         got = {TXENPMAPHASEALIGN, TXPMASETPHASE, SYNC_DONE};
         n_checks++;
         if (got !== exp) begin
            n_errors++;
            $display("FAIL abort_setphase edge %0d: got %b want %b", k, got, exp);
         end
         if (k == 20) GTX_RST = 1'b1;
         if (k == 30) GTX_RST = 1'b0;
      end
      exp_cnt = 2;
`ifdef TX_SYNC_CNT_EN
      n_checks++;
      if (SYNC_CNT !== 8'(exp_cnt)) begin
         n_errors++;
         $display("FAIL abort_sync_cnt: got %0d want %0d", SYNC_CNT, exp_cnt);
      end
`endif
   endtask

   task automatic test_glitch_done();
      logic [2:0] got;
      logic [2:0] exp;
      TXRESETDONE = 1'b0;                             // edge 0, block is in Done
      for (int k = 1; k <= 31; k++) begin
         step();
         exp = (k == 1) ? 3'b000 : exp_out(k - 1);
         got = {TXENPMAPHASEALIGN, TXPMASETPHASE, SYNC_DONE};
         n_checks++;
         if (got !== exp) begin
            n_errors++;
            $display("FAIL glitch_done edge %0d: got %b want %b", k, got, exp);
         end
         if (k == 1) TXRESETDONE = 1'b1;
      end
      exp_cnt = 3;
`ifdef TX_SYNC_CNT_EN
      n_checks++;
      if (SYNC_CNT !== 8'(exp_cnt)) begin
         n_errors++;
         $display("FAIL glitch_sync_cnt: got %0d want %0d", SYNC_CNT, exp_cnt);
      end
`endif
   endtask

   task automatic test_rst_mid_align();
      logic [2:0] got;
      logic [2:0] exp;
      GTX_RST = 1'b1;
      step();
      GTX_RST = 1'b0;                                 // edge 0
      for (int k = 1; k <= 39; k++) begin
         step();
         if (k <= 8)       exp = exp_out(k);
         else if (k == 9)  exp = 3'b000;
         else              exp = exp_out(k - 9);
         got = {TXENPMAPHASEALIGN, TXPMASETPHASE, SYNC_DONE};
         n_checks++;
         if (got !== exp) begin
            n_errors++;
            $display("FAIL rst_mid_align edge %0d: got %b want %b", k, got, exp);
         end
`ifdef TX_SYNC_CNT_EN
         if (k == 9) begin
            n_checks++;
            if (SYNC_CNT !== 8'd0) begin
               n_errors++;
               $display("FAIL rst_sync_cnt: got %0d want 0", SYNC_CNT);
            end
         end
`endif
         if (k == 8) RST = 1'b1;
         if (k == 9) RST = 1'b0;
      end
      exp_cnt = 1;
`ifdef TX_SYNC_CNT_EN
      n_checks++;
      if (SYNC_CNT !== 8'(exp_cnt)) begin
         n_errors++;
         $display("FAIL rst_restart_sync_cnt: got %0d want %0d", SYNC_CNT, exp_cnt);
      end
`endif
   endtask

   task automatic test_simultaneous();
      logic [2:0] got;
      logic [2:0] exp;
      GTX_RST = 1'b1; TXRESETDONE = 1'b0;
      step();
      step();
      TXRESETDONE = 1'b1;                             // edge 0, GTX_RST still high
      for (int k = 1; k <= 40; k++) begin
         step();
         exp = (k <= 5) ? 3'b000 : exp_out(k - 5);
         got = {TXENPMAPHASEALIGN, TXPMASETPHASE, SYNC_DONE};
         n_checks++;
         if (got !== exp) begin
            n_errors++;
            $display("FAIL simultaneous edge %0d: got %b want %b", k, got, exp);
         end
         if (k == 5) GTX_RST = 1'b0;
      end
      exp_cnt = 2;
`ifdef TX_SYNC_CNT_EN
      n_checks++;
      if (SYNC_CNT !== 8'(exp_cnt)) begin
         n_errors++;
         $display("FAIL simultaneous_sync_cnt: got %0d want %0d", SYNC_CNT, exp_cnt);
      end
`endif
   endtask

`ifdef TX_SYNC_CNT_EN
   task automatic test_sync_cnt_saturate();
      for (int i = 0; i < 300; i++) begin
         GTX_RST = 1'b1;
         step();
         GTX_RST = 1'b0;                              // edge 0
         for (int k = 1; k <= DONE_EDGE; k++) step();
         if (exp_cnt < 255) exp_cnt++;
         n_checks++;
         if (SYNC_CNT !== 8'(exp_cnt) || SYNC_DONE !== 1'b1) begin
            n_errors++;
            $display("FAIL saturate iter %0d: got cnt %0d done %b want cnt %0d done 1",
                     i, SYNC_CNT, SYNC_DONE, exp_cnt);
         end
      end
      GTX_RST = 1'b1;
      step();
      step();
      n_checks++;
      if (SYNC_CNT !== 8'd255 || SYNC_DONE !== 1'b0) begin
         n_errors++;
         $display("FAIL gtx_rst_keeps_cnt: got cnt %0d done %b want cnt 255 done 0",
                  SYNC_CNT, SYNC_DONE);
      end
      GTX_RST = 1'b0;
   endtask
`endif

   initial begin
      RST = 1'b1; GTX_RST = 1'b1; TXRESETDONE = 1'b0;
      test_reset();
      test_bringup();
      test_abort_setphase();
      test_glitch_done();
      test_rst_mid_align();
      test_simultaneous();
`ifdef TX_SYNC_CNT_EN
      test_sync_cnt_saturate();
`endif
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
